// File: rtl/matrix_snoop.sv
// rtl/matrix_snoop.sv - receive end of the 8x8 RGB matrix shift link with wishbone row/status readback
// Optional glitch filter: MATRIX_SNOOP_GLITCH_FILTER_EN
module matrix_snoop #(
   parameter int WORD_BITS   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_matrix_clk,
   input  logic        i_matrix_latch,
   input  logic        i_matrix_mosi,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_addr,
   input  logic [3:0]  i_wb_sel,
   input  logic [31:0] i_wb_wdata,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic [31:0] o_wb_rdata,
   output logic        o_frame_strobe
);
   localparam logic [5:0] FULL_CNT = 6'(WORD_BITS);

   logic [SYNC_STAGES-1:0] sync_clk, sync_lat, sync_mosi;
   logic f_clk, f_lat, f_mosi;
   logic h_clk, h_lat;
   logic clk_rise, lat_rise;

   logic [WORD_BITS-1:0] shreg, shifted, word_eff;
   logic [5:0]  bit_cnt, bit_cnt_inc, cnt_eff;
   logic [7:0]  row_sel;
   logic        one_hot;
   logic [2:0]  row_idx;
   logic [23:0] rows [8];
   logic [7:0]  frame_cnt, len_err, row_err;
   logic [5:0]  last_bits;
   logic [31:0] status, rd_mux;
   logic        req, wb_clear;
   logic        unused_ok;

   assign unused_ok  = ^{i_wb_wdata, i_wb_sel[3:1]};
   assign o_wb_stall = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_clk  <= '0;
         sync_lat  <= '0;
         sync_mosi <= '0;
      end else begin
         sync_clk  <= {sync_clk[SYNC_STAGES-2:0], i_matrix_clk};
         sync_lat  <= {sync_lat[SYNC_STAGES-2:0], i_matrix_latch};
         sync_mosi <= {sync_mosi[SYNC_STAGES-2:0], i_matrix_mosi};
      end
   end

`ifdef MATRIX_SNOOP_GLITCH_FILTER_EN
   // 3-sample majority over the synced signal; a single-clock pulse never wins the vote
   logic [1:0] fh_clk, fh_lat, fh_mosi;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         fh_clk  <= '0;
         fh_lat  <= '0;
         fh_mosi <= '0;
         f_clk   <= 1'b0;
         f_lat   <= 1'b0;
         f_mosi  <= 1'b0;
      end else begin
         fh_clk  <= {fh_clk[0], sync_clk[SYNC_STAGES-1]};
         fh_lat  <= {fh_lat[0], sync_lat[SYNC_STAGES-1]};
         fh_mosi <= {fh_mosi[0], sync_mosi[SYNC_STAGES-1]};
         f_clk   <= maj3(sync_clk[SYNC_STAGES-1], fh_clk[0], fh_clk[1]);
         f_lat   <= maj3(sync_lat[SYNC_STAGES-1], fh_lat[0], fh_lat[1]);
         f_mosi  <= maj3(sync_mosi[SYNC_STAGES-1], fh_mosi[0], fh_mosi[1]);
      end
   end
`else
   assign f_clk  = sync_clk[SYNC_STAGES-1];
   assign f_lat  = sync_lat[SYNC_STAGES-1];
   assign f_mosi = sync_mosi[SYNC_STAGES-1];
`endif

   assign clk_rise = f_clk & ~h_clk;
   assign lat_rise = f_lat & ~h_lat;

   // A latch edge coinciding with a shift edge sees the word with that bit already included
   assign bit_cnt_inc = (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
   assign shifted     = {shreg[WORD_BITS-2:0], f_mosi};
   assign cnt_eff     = clk_rise ? bit_cnt_inc : bit_cnt;
   assign word_eff    = clk_rise ? shifted : shreg;
   assign row_sel     = word_eff[WORD_BITS-1 -: 8];
   assign one_hot     = (row_sel != 8'd0) && ((row_sel & (row_sel - 8'd1)) == 8'd0);

   always_comb begin
      row_idx = 3'd0;
      for (int i = 0; i < 8; i++)
         if (row_sel[i]) row_idx = 3'(i);
   end

   assign status   = {frame_cnt, len_err, row_err, 2'b00, last_bits};
   assign req      = i_wb_cyc & i_wb_stb;
   assign wb_clear = req & i_wb_we & (i_wb_addr == 4'd8) & i_wb_sel[0];

   always_comb begin
      rd_mux = 32'd0;
      if (!i_wb_addr[3])          rd_mux = {8'h00, rows[i_wb_addr[2:0]]};
      else if (i_wb_addr == 4'd8) rd_mux = status;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_clk          <= 1'b0;
         h_lat          <= 1'b0;
         shreg          <= '0;
         bit_cnt        <= '0;
         frame_cnt      <= '0;
         len_err        <= '0;
         row_err        <= '0;
         last_bits      <= '0;
         o_frame_strobe <= 1'b0;
         o_wb_ack       <= 1'b0;
         o_wb_rdata     <= '0;
         for (int i = 0; i < 8; i++) rows[i] <= '0;
      end else begin
         h_clk          <= f_clk;
         h_lat          <= f_lat;
         o_frame_strobe <= 1'b0;
         if (clk_rise) begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt_inc;
         end
         if (lat_rise) begin
            bit_cnt   <= 6'd0;
            last_bits <= cnt_eff;
            if (cnt_eff != FULL_CNT) begin
               if (len_err != 8'hFF) len_err <= len_err + 8'd1;
            end else if (!one_hot) begin
               if (row_err != 8'hFF) row_err <= row_err + 8'd1;
            end else begin
               rows[row_idx] <= word_eff[23:0];
               if (row_idx == 3'd7) begin
                  frame_cnt      <= frame_cnt + 8'd1;
                  o_frame_strobe <= 1'b1;
               end
            end
         end
         if (wb_clear) begin
            frame_cnt <= '0;
            len_err   <= '0;
            row_err   <= '0;
            last_bits <= '0;
         end
         o_wb_ack <= req;
         if (req) o_wb_rdata <= rd_mux;
      end
   end
endmodule

// File: tb/tb_matrix_snoop.sv
// tb/tb_matrix_snoop.sv - scoreboard bench for matrix_snoop link decode and wishbone readback
module tb_matrix_snoop;
   logic        clk = 1'b0;
   logic        reset;
   logic        m_clk, m_latch, m_mosi;
   logic        cyc, stb, we;
   logic [3:0]  addr, sel;
   logic [31:0] wdata;
   logic        ack, stall, strobe;
   logic [31:0] rdata;

   typedef struct {
      bit          chk;
      logic [31:0] val;
      int          tag;
   } exp_t;
   exp_t q[$];

   int checks = 0;
   int fails  = 0;
   int strobes = 0;

   matrix_snoop dut (
      .clk(clk), .reset(reset),
      .i_matrix_clk(m_clk), .i_matrix_latch(m_latch), .i_matrix_mosi(m_mosi),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
      .i_wb_sel(sel), .i_wb_wdata(wdata),
      .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_rdata(rdata),
      .o_frame_strobe(strobe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (strobe) strobes++;
         if (ack) begin
            if (q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL spurious_ack: got ack with empty scoreboard, expected none");
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.chk) check($sformatf("read_%0d", e.tag), rdata, e.val);
            end
         end
      end
   end

   task automatic wb_req(input logic w, input logic [3:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] exp, input int tag);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; wdata = d;
      q.push_back('{chk: !w, val: exp, tag: tag});
   endtask

   task automatic wb_idle();
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input int tag);
      wb_req(1'b0, a, 4'h0, 32'd0, exp, tag);
      wb_idle();
   endtask

   task automatic wr(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d);
      wb_req(1'b1, a, s, d, 32'd0, 0);
      wb_idle();
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         check("drain_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
   endtask

   task automatic shift_bits(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         m_mosi = w[31-i];
         repeat (2) @(negedge clk);
         m_clk = 1'b1;
         repeat (4) @(negedge clk);
         m_clk = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic latch();
      repeat (2) @(negedge clk);
      m_latch = 1'b1;
      repeat (4) @(negedge clk);
      m_latch = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic send(input logic [31:0] w);
      shift_bits(w, 32);
      latch();
   endtask

   initial begin
      reset = 1'b1; m_clk = 1'b0; m_latch = 1'b0; m_mosi = 1'b0;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
      repeat (3) @(negedge clk);
      check("reset_ack", {31'd0, ack}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_strobe", {31'd0, strobe}, 32'd0);
      check("stall", {31'd0, stall}, 32'd0);
      reset = 1'b0;
      rd(4'd8, 32'h0000_0000, 100);

      // single row 0 word
      send(32'h01FF_0000);
      rd(4'd0, 32'h00FF_0000, 1);
      rd(4'd8, 32'h0000_0020, 2);

      // full frame rows 0..7
      for (int r = 0; r < 8; r++) send({8'h01 << r, 24'h000001 << r});
      check("frame_strobes", 32'(strobes), 32'd1);
      for (int r = 0; r < 8; r++) wb_req(1'b0, 4'(r), 4'h0, 32'd0, 32'h1 << r, 10 + r);
      wb_idle();
      rd(4'd8, 32'h0100_0020, 3);

      // short word
      shift_bits(32'h02AB_CDEF, 31);
      latch();
      rd(4'd8, 32'h0101_001F, 4);
      rd(4'd1, 32'h0000_0002, 5);

      // bad row field, then clear
      send(32'h0312_3456);
      rd(4'd8, 32'h0101_0120, 6);
      rd(4'd0, 32'h0000_0001, 7);
      wr(4'd8, 4'h1, 32'hDEAD_BEEF);
      rd(4'd8, 32'h0000_0000, 8);

      // ignored row write, reserved read
      wr(4'd3, 4'hF, 32'hFFFF_FFFF);
      rd(4'd3, 32'h0000_0008, 9);
      rd(4'd12, 32'h0000_0000, 20);

      // 32nd shift edge and latch edge in the same cycle
      shift_bits(32'h20A5_A5A5, 31);
      m_mosi = 1'b1;
      repeat (2) @(negedge clk);
      m_clk = 1'b1; m_latch = 1'b1;
      repeat (4) @(negedge clk);
      m_clk = 1'b0; m_latch = 1'b0;
      repeat (8) @(negedge clk);
      rd(4'd5, 32'h00A5_A5A5, 21);
      rd(4'd8, 32'h0000_0020, 22);

      // single-clock glitch on the shift clock
      shift_bits(32'h0400_0000, 30);
      @(negedge clk);
      m_clk = 1'b1;
      @(negedge clk);
      m_clk = 1'b0;
      repeat (6) @(negedge clk);
      latch();
`ifdef MATRIX_SNOOP_GLITCH_FILTER_EN
      rd(4'd8, 32'h0001_001E, 23);
`else
      rd(4'd8, 32'h0001_001F, 23);
`endif
      check("frame_strobes_end", 32'(strobes), 32'd1);

      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
